// File: rtl/branch_prediction_buffer_pkg.sv
// Shared types for the fetch-stage branch prediction buffer.
// Counter encoding, table entry layout and default table size.
package branch_prediction_buffer_pkg;

    localparam int BPB_ENTRIES = 16;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_counter_type;

    // Tag is held zero-extended to 32 bits so the layout does not
    // depend on the table size; unused upper bits stay constant.
    typedef struct packed {
        logic           valid;
        logic [31:0]    tag;
        bp_counter_type counter;
        logic [31:0]    target;
    } bpb_entry_type;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_prediction_buffer_sat_counter.sv
// Two-bit saturating counter next-state function.
// Purely combinational; the state lives in the prediction table.
module bp_sat_counter
    import branch_prediction_buffer_pkg::*;
(
    input  bp_counter_type counter,
    input  logic           taken,
    output bp_counter_type next
);

    // Step toward ST on taken, toward SNT otherwise, clamping at the ends
    always_comb begin
        next = counter;
        unique case (counter)
            SNT: next = taken ? WNT : SNT;
            WNT: next = taken ? WT  : SNT;
            WT:  next = taken ? ST  : WNT;
            ST:  next = taken ? ST  : WT;
            default: next = counter;
        endcase
    end

endmodule

// File: rtl/branch_prediction_buffer.sv
// Direct-mapped branch prediction buffer with 2-bit counters and targets.
// Predicts combinationally at fetch, trains and checks at branch resolve.
module branch_prediction_buffer
    import branch_prediction_buffer_pkg::*;
#(
    parameter int ENTRIES    = BPB_ENTRIES,
    parameter int INDEX_BITS = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] fetch_pc,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        resolve,
    input  logic [31:0] resolve_pc,
    input  logic        resolve_taken,
    input  logic [31:0] resolve_target,
    input  logic        resolve_compressed,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] recover_pc,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    bpb_entry_type table_q [ENTRIES];

    logic [INDEX_BITS-1:0] f_idx;
    logic [31:0]           f_tag;
    bpb_entry_type         f_entry;
    logic                  f_hit;
    logic [1:0]            f_ctr;

    logic [INDEX_BITS-1:0] r_idx;
    logic [31:0]           r_tag;
    bpb_entry_type         r_entry;
    logic                  r_hit;
    bp_counter_type        r_next;

    logic                  miss_pred;
    logic [31:0]           fall_pc;
    logic [31:0]           correct_pc;

    // Bit 0 of a PC is always zero for RISC-V instructions
    logic unused_pc_bit;
    assign unused_pc_bit = fetch_pc[0] ^ resolve_pc[0];

    // Fetch-side lookup from current table contents (no bypass)
    always_comb begin
        f_idx   = fetch_pc[INDEX_BITS:1];
        f_tag   = {{(INDEX_BITS+1){1'b0}}, fetch_pc[31:INDEX_BITS+1]};
        f_entry = table_q[f_idx];
        f_hit   = f_entry.valid && (f_entry.tag == f_tag);
        f_ctr   = f_entry.counter;
        predict_taken  = f_hit && f_ctr[1];
        predict_target = predict_taken ? f_entry.target : 32'd0;
    end

    // Resolve-side lookup of the entry being trained
    always_comb begin
        r_idx   = resolve_pc[INDEX_BITS:1];
        r_tag   = {{(INDEX_BITS+1){1'b0}}, resolve_pc[31:INDEX_BITS+1]};
        r_entry = table_q[r_idx];
        r_hit   = r_entry.valid && (r_entry.tag == r_tag);
    end

    bp_sat_counter u_ctr (
        .counter (r_entry.counter),
        .taken   (resolve_taken),
        .next    (r_next)
    );

    // Misprediction decision and correct next PC for the resolving branch
    always_comb begin
        fall_pc    = resolve_pc + (resolve_compressed ? 32'd2 : 32'd4);
        correct_pc = resolve_taken ? resolve_target : fall_pc;
        miss_pred  = (resolve_taken != ex_pred_taken) ||
                     (resolve_taken && (resolve_target != ex_pred_target));
    end

    // Table training: update on hit, allocate on taken miss
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i].valid   <= 1'b0;
                table_q[i].tag     <= 32'd0;
                table_q[i].counter <= WNT;
                table_q[i].target  <= 32'd0;
            end
        end else if (resolve) begin
            if (r_hit) begin
                table_q[r_idx].counter <= r_next;
                if (resolve_taken) begin
                    table_q[r_idx].target <= resolve_target;
                end
            end else if (resolve_taken) begin
                table_q[r_idx].valid   <= 1'b1;
                table_q[r_idx].tag     <= r_tag;
                table_q[r_idx].counter <= WT;
                table_q[r_idx].target  <= resolve_target;
            end
        end
    end

    // One-cycle redirect pulse; recover_pc holds between resolves
    always_ff @(posedge clk) begin
        if (reset) begin
            mispredict <= 1'b0;
            recover_pc <= 32'd0;
        end else begin
            mispredict <= resolve && miss_pred;
            if (resolve) begin
                recover_pc <= correct_pc;
            end
        end
    end

    // Saturating branch and misprediction statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else if (resolve) begin
            branch_count <= sat_inc32(branch_count);
            if (miss_pred) begin
                mispredict_count <= sat_inc32(mispredict_count);
            end
        end
    end

endmodule

// File: tb/tb_branch_prediction_buffer.sv
// Self-checking bench for branch_prediction_buffer.
// Vector table plus hand sequences; redirect outputs via a scoreboard queue.
module tb_branch_prediction_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] fetch_pc;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        resolve;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic [31:0] resolve_target;
    logic        resolve_compressed;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] recover_pc;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    int checks = 0;
    int errors = 0;
    int exp_bc = 0;
    int exp_mc = 0;

    typedef struct {
        logic        mis;
        logic [31:0] rpc;
    } sb_t;

    sb_t sb_q[$];

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        comp;
        logic        ept;
        logic [31:0] eptt;
        logic        emis;
        logic [31:0] erpc;
        logic [31:0] lpc;
        logic        lt;
        logic [31:0] ltgt;
    } vec_t;

    vec_t vecs[15];

    branch_prediction_buffer dut (
        .clk                (clk),
        .reset              (reset),
        .fetch_pc           (fetch_pc),
        .predict_taken      (predict_taken),
        .predict_target     (predict_target),
        .resolve            (resolve),
        .resolve_pc         (resolve_pc),
        .resolve_taken      (resolve_taken),
        .resolve_target     (resolve_target),
        .resolve_compressed (resolve_compressed),
        .ex_pred_taken      (ex_pred_taken),
        .ex_pred_target     (ex_pred_target),
        .mispredict         (mispredict),
        .recover_pc         (recover_pc),
        .branch_count       (branch_count),
        .mispredict_count   (mispredict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic et, input logic [31:0] etgt);
        fetch_pc = pc;
        #1;
        chk({name, " taken"}, {31'd0, predict_taken}, {31'd0, et});
        chk({name, " target"}, predict_target, etgt);
    endtask

    task automatic pop_check(input string name);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty got %0d expected 1", name, 0);
        end else begin
            e = sb_q.pop_front();
            chk({name, " mispredict"}, {31'd0, mispredict}, {31'd0, e.mis});
            chk({name, " recover_pc"}, recover_pc, e.rpc);
        end
    endtask

    task automatic step(input string name, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt,
                        input logic cp, input logic ept,
                        input logic [31:0] eptt, input logic emis,
                        input logic [31:0] erpc);
        sb_t e;
        @(negedge clk);
        resolve            = 1'b1;
        resolve_pc         = pc;
        resolve_taken      = tk;
        resolve_target     = tgt;
        resolve_compressed = cp;
        ex_pred_taken      = ept;
        ex_pred_target     = eptt;
        e.mis = emis;
        e.rpc = erpc;
        sb_q.push_back(e);
        exp_bc++;
        if (emis) exp_mc++;
        @(posedge clk);
        #1;
        resolve = 1'b0;
        pop_check(name);
        chk({name, " branch_count"}, branch_count, exp_bc);
        chk({name, " mispredict_count"}, mispredict_count, exp_mc);
    endtask

    initial begin
        vecs[0]  = '{32'h100, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,
                     1'b0, 32'h104, 32'h100, 1'b0, 32'h0};
        vecs[1]  = '{32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,
                     1'b1, 32'h80,  32'h100, 1'b1, 32'h80};
        vecs[2]  = '{32'h100, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,
                     1'b1, 32'h104, 32'h100, 1'b0, 32'h0};
        vecs[3]  = '{32'h100, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,
                     1'b0, 32'h104, 32'h100, 1'b0, 32'h0};
        vecs[4]  = '{32'h100, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,
                     1'b0, 32'h104, 32'h100, 1'b0, 32'h0};
        vecs[5]  = '{32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,
                     1'b1, 32'h80,  32'h100, 1'b0, 32'h0};
        vecs[6]  = '{32'h100, 1'b1, 32'h80, 1'b0, 1'b0, 32'h0,
                     1'b1, 32'h80,  32'h100, 1'b1, 32'h80};
        vecs[7]  = '{32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80,
                     1'b0, 32'h80,  32'h100, 1'b1, 32'h80};
        vecs[8]  = '{32'h100, 1'b1, 32'h80, 1'b0, 1'b1, 32'h80,
                     1'b0, 32'h80,  32'h100, 1'b1, 32'h80};
        vecs[9]  = '{32'h100, 1'b0, 32'h0,  1'b0, 1'b1, 32'h80,
                     1'b1, 32'h104, 32'h100, 1'b1, 32'h80};
        vecs[10] = '{32'h100, 1'b1, 32'h90, 1'b0, 1'b1, 32'h80,
                     1'b1, 32'h90,  32'h100, 1'b1, 32'h90};
        vecs[11] = '{32'h120, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0,
                     1'b1, 32'h40,  32'h100, 1'b0, 32'h0};
        vecs[12] = '{32'h200, 1'b0, 32'h0,  1'b1, 1'b1, 32'h300,
                     1'b1, 32'h202, 32'h200, 1'b0, 32'h0};
        vecs[13] = '{32'h200, 1'b0, 32'h0,  1'b0, 1'b1, 32'h300,
                     1'b1, 32'h204, 32'h200, 1'b0, 32'h0};
        vecs[14] = '{32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0, 1'b1, 32'h8,
                     1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0};

        reset = 1'b1;
        fetch_pc = 32'h0;
        resolve = 1'b0;
        resolve_pc = 32'h0;
        resolve_taken = 1'b0;
        resolve_target = 32'h0;
        resolve_compressed = 1'b0;
        ex_pred_taken = 1'b0;
        ex_pred_target = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst recover_pc", recover_pc, 32'd0);
        chk("rst branch_count", branch_count, 32'd0);
        chk("rst mispredict_count", mispredict_count, 32'd0);
        look("rst lookup", 32'h100, 1'b0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), vecs[i].pc, vecs[i].taken,
                 vecs[i].tgt, vecs[i].comp, vecs[i].ept, vecs[i].eptt,
                 vecs[i].emis, vecs[i].erpc);
            look($sformatf("vec%0d lookup", i), vecs[i].lpc,
                 vecs[i].lt, vecs[i].ltgt);
        end

        look("alias new", 32'h120, 1'b1, 32'h40);

        step("alloc300", 32'h300, 1'b1, 32'h500, 1'b0, 1'b0, 32'h0,
             1'b1, 32'h500);
        @(posedge clk);
        #1;
        chk("pulse end", {31'd0, mispredict}, 32'd0);
        chk("rpc hold", recover_pc, 32'h500);

        @(negedge clk);
        fetch_pc           = 32'h300;
        resolve            = 1'b1;
        resolve_pc         = 32'h300;
        resolve_taken      = 1'b0;
        resolve_target     = 32'h0;
        resolve_compressed = 1'b0;
        ex_pred_taken      = 1'b1;
        ex_pred_target     = 32'h500;
        sb_q.push_back('{1'b1, 32'h304});
        exp_bc++;
        exp_mc++;
        #1;
        chk("same-cycle old taken", {31'd0, predict_taken}, 32'd1);
        chk("same-cycle old target", predict_target, 32'h500);
        @(posedge clk);
        #1;
        resolve = 1'b0;
        pop_check("same-cycle");
        look("after update", 32'h300, 1'b0, 32'h0);

        @(negedge clk);
        reset              = 1'b1;
        resolve            = 1'b1;
        resolve_pc         = 32'h400;
        resolve_taken      = 1'b1;
        resolve_target     = 32'h10;
        ex_pred_taken      = 1'b0;
        ex_pred_target     = 32'h0;
        sb_q.push_back('{1'b0, 32'h0});
        exp_bc = 0;
        exp_mc = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        resolve = 1'b0;
        pop_check("reset+resolve");
        chk("reset+resolve branch_count", branch_count, exp_bc);
        chk("reset+resolve mispredict_count", mispredict_count, exp_mc);
        look("reset lookup 400", 32'h400, 1'b0, 32'h0);
        look("reset lookup 300", 32'h300, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        chk("reset no pulse", {31'd0, mispredict}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
